// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters decoded into registered
// sync, data-enable, coordinate and line/frame strobe outputs.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS   = CW'(V_ACTIVE);
    // Inclusive sync bounds so the end value never wraps when 2**CW == total
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic de_c;
    logic hs_act_c;
    logic vs_act_c;

    // Raster position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    always_comb begin
        de_c     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_act_c = (h_cnt >= HS_BEG) && (h_cnt <= HS_LAST);
        vs_act_c = (v_cnt >= VS_BEG) && (v_cnt <= VS_LAST);
    end

    // Outputs describe the counter state of the previous cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_act_c ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_act_c ? SYNC_POL : ~SYNC_POL;
            de          <= de_c;
            px_x        <= de_c ? h_cnt : '0;
            px_y        <= de_c ? v_cnt : '0;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance,
// per-cycle scoreboard from a cycle-count model, vector table and corner sequences.
module tb_vga_timing_gen;

    localparam int unsigned DCW = 10;
    localparam int unsigned SCW = 4;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] x;
        logic [15:0] y;
        logic        ls;
        logic        fs;
    } rec_t;

    typedef struct {
        int   n;
        rec_t r;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_s;
    logic d_hsync, d_vsync, d_de, d_line_start, d_frame_start;
    logic [DCW-1:0] d_px_x, d_px_y;
    logic s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
    logic [SCW-1:0] s_px_x, s_px_y;

    vga_timing_gen u_dflt (
        .clk(clk), .rst(rst_d), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
        .px_x(d_px_x), .px_y(d_px_y), .line_start(d_line_start), .frame_start(d_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CW(SCW)
    ) u_small (
        .clk(clk), .rst(rst_s), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
        .px_x(s_px_x), .px_y(s_px_y), .line_start(s_line_start), .frame_start(s_frame_start)
    );

    int errors = 0;
    int checks = 0;
    rec_t q_d[$];
    rec_t q_s[$];
    int n_d = 0;
    int n_s = 0;

    function automatic rec_t mk(logic hs, logic vs, logic de, int x, int y, logic ls, logic fs);
        rec_t r;
        r.hs = hs; r.vs = vs; r.de = de;
        r.x = 16'(x); r.y = 16'(y);
        r.ls = ls; r.fs = fs;
        return r;
    endfunction

    // Expected outputs for the n-th cycle after reset release
    function automatic rec_t model(int n, int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp, bit pol);
        int ht, vt, h, v;
        logic de, hs, vs;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        h  = n % ht;
        v  = (n / ht) % vt;
        de = (h < ha) && (v < va);
        hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
        vs = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
        return mk(hs, vs, de, de ? h : 0, de ? v : 0, h == 0, (h == 0) && (v == 0));
    endfunction

    function automatic rec_t rst_rec(bit pol);
        return mk(~pol, ~pol, 1'b0, 0, 0, 1'b0, 1'b0);
    endfunction

    function automatic rec_t cur_d();
        return mk(d_hsync, d_vsync, d_de, int'(d_px_x), int'(d_px_y), d_line_start, d_frame_start);
    endfunction

    function automatic rec_t cur_s();
        return mk(s_hsync, s_vsync, s_de, int'(s_px_x), int'(s_px_y), s_line_start, s_frame_start);
    endfunction

    task automatic chk_rec(string name, rec_t got, rec_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                     name, $time, got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs,
                     exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboards: push expectation at the edge, pop and compare just after it
    always @(posedge clk) begin
        if (rst_d) begin
            q_d.push_back(rst_rec(1'b0));
            n_d = 0;
        end else begin
            q_d.push_back(model(n_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            n_d++;
        end
        #1;
        chk_rec("dflt_sb", cur_d(), q_d.pop_front());
    end

    always @(posedge clk) begin
        if (rst_s) begin
            q_s.push_back(rst_rec(1'b1));
            n_s = 0;
        end else begin
            q_s.push_back(model(n_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
            n_s++;
        end
        #1;
        chk_rec("small_sb", cur_s(), q_s.pop_front());
    end

    initial begin
        vec_t tbl[10];
        int cur;
        int de_cnt, hs_cnt, vs_lo, hs_first, de_fall, ls_cnt, ls_pos;
        logic de_prev;
        int t1, t2, vs_hi, de_hi, hs_hi;
        bit found;

        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        rst_s = 1'b0;

        tbl[0] = '{0,    mk(1, 1, 1, 0,   0, 1, 1)};
        tbl[1] = '{1,    mk(1, 1, 1, 1,   0, 0, 0)};
        tbl[2] = '{639,  mk(1, 1, 1, 639, 0, 0, 0)};
        tbl[3] = '{640,  mk(1, 1, 0, 0,   0, 0, 0)};
        tbl[4] = '{655,  mk(1, 1, 0, 0,   0, 0, 0)};
        tbl[5] = '{656,  mk(0, 1, 0, 0,   0, 0, 0)};
        tbl[6] = '{751,  mk(0, 1, 0, 0,   0, 0, 0)};
        tbl[7] = '{752,  mk(1, 1, 0, 0,   0, 0, 0)};
        tbl[8] = '{800,  mk(1, 1, 1, 0,   1, 1, 0)};
        tbl[9] = '{1601, mk(1, 1, 1, 1,   2, 0, 0)};

        cur = -1;
        for (int i = 0; i < 10; i++) begin
            repeat (tbl[i].n - cur) @(posedge clk);
            cur = tbl[i].n;
            #2;
            chk_rec($sformatf("dflt_vec%0d", i), cur_d(), tbl[i].r);
        end

        // One full line (line 3) of the default raster
        repeat (2399 - cur) @(posedge clk);
        cur = 2399;
        de_cnt = 0; hs_cnt = 0; vs_lo = 0; hs_first = -1; de_fall = -1;
        ls_cnt = 0; ls_pos = -1; de_prev = 1'b0;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #2;
            cur++;
            if (d_de) de_cnt++;
            if (!d_hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
            if (!d_vsync) vs_lo++;
            if (de_prev && !d_de && de_fall < 0) de_fall = k;
            de_prev = d_de;
            if (d_line_start) begin
                ls_cnt++;
                ls_pos = k;
            end
        end
        chk_int("line_de_high", de_cnt, 640);
        chk_int("line_de_fall", de_fall, 640);
        chk_int("line_hsync_low", hs_cnt, 96);
        chk_int("line_hsync_after_de", hs_first - de_fall, 16);
        chk_int("line_vsync_low", vs_lo, 0);
        chk_int("line_start_count", ls_cnt, 1);
        chk_int("line_start_pos", ls_pos, 0);

        // Asynchronous reset mid-line on the default raster
        repeat (200) @(negedge clk);
        #2;
        rst_d = 1'b1;
        #1;
        chk_rec("dflt_async_rst", cur_d(), rst_rec(1'b0));
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        @(posedge clk);
        #2;
        chk_rec("dflt_restart", cur_d(), mk(1, 1, 1, 0, 0, 1, 1));

        // Tiny raster: frame period and per-frame pulse counts
        t1 = -1; t2 = -1;
        for (int k = 0; k < 300 && t2 < 0; k++) begin
            @(posedge clk);
            #2;
            if (s_frame_start) begin
                if (t1 < 0) t1 = k;
                else t2 = k;
            end
        end
        chk_int("small_frame_period", t2 - t1, 98);
        vs_hi = int'(s_vsync); de_hi = int'(s_de); hs_hi = int'(s_hsync);
        for (int k = 1; k < 98; k++) begin
            @(posedge clk);
            #2;
            vs_hi += int'(s_vsync);
            de_hi += int'(s_de);
            hs_hi += int'(s_hsync);
        end
        chk_int("small_vsync_high", vs_hi, 14);
        chk_int("small_de_high", de_hi, 32);
        chk_int("small_hsync_high", hs_hi, 14);

        // Tiny raster: async reset at line 3 pixel 5
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (s_de && s_px_y == SCW'(3) && s_px_x == SCW'(5)) found = 1'b1;
        end
        chk_int("small_reach_pixel", int'(found), 1);
        #2;
        rst_s = 1'b1;
        #1;
        chk_rec("small_async_rst", cur_s(), rst_rec(1'b1));
        repeat (2) @(negedge clk);
        rst_s = 1'b0;
        @(posedge clk);
        #2;
        chk_rec("small_restart", cur_s(), mk(0, 0, 1, 0, 0, 1, 1));

        repeat (20) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
